// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus: region decode, DMA states,
// and the internal bus access record.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_PPU,
    RGN_IO,
    RGN_OPEN,
    RGN_CART
  } region_e;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_RD,
    DMA_WR
  } dma_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
  } bus_acc_t;

  localparam logic [15:0] PPU_BASE     = 16'h2000;
  localparam logic [15:0] IO_BASE      = 16'h4000;
  localparam logic [15:0] OPEN_BASE    = 16'h4018;
  localparam logic [15:0] CART_BASE    = 16'h4020;
  localparam logic [15:0] OAM_DMA_REG  = 16'h4014;
  localparam logic [2:0]  OAM_DATA_IDX = 3'd4;

  function automatic region_e decode_region(input logic [15:0] a);
    if (a < PPU_BASE)  return RGN_RAM;
    if (a < IO_BASE)   return RGN_PPU;
    if (a < OPEN_BASE) return RGN_IO;
    if (a < CART_BASE) return RGN_OPEN;
    return RGN_CART;
  endfunction

endpackage

// File: rtl/cpu_bus_ram.sv
// Internal work RAM: 2^AW x 8, single port, registered read (one-cycle latency).
module cpu_ram #(
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/cpu_bus.sv
// CPU bus decoder with RAM, PPU/IO/cart windows, open-bus latch and optional
// OAM DMA engine (enable with macro OAM_DMA_EN).
module cpu_bus
  import cpu_bus_pkg::*;
#(
  parameter int RAM_AW = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        mem_r_en,
  input  logic [7:0]  w_data,
  output logic [7:0]  r_data,
  output logic        cpu_stall,
  output logic [2:0]  ppu_addr,
  output logic        ppu_rd,
  output logic        ppu_wr,
  input  logic [7:0]  ppu_rdata,
  output logic [4:0]  io_addr,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [7:0]  io_rdata,
  output logic [15:0] cart_addr,
  output logic        cart_rd,
  output logic        cart_wr,
  input  logic [7:0]  cart_rdata,
  output logic [7:0]  bus_wdata
);

  bus_acc_t   w_acc;
  region_e    w_region, r_rd_region;
  logic       w_core_en, w_live, r_rd_pend;
  logic [7:0] r_open, w_ram_q, w_sel;

`ifdef OAM_DMA_EN
  dma_state_e r_state, w_next;
  logic       r_parity, w_kick;
  logic [7:0] r_page, r_idx;

  assign w_core_en = (r_state == DMA_IDLE);
  assign w_kick    = w_core_en && !mem_r_en && (address == OAM_DMA_REG);
  assign cpu_stall = !w_core_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= DMA_IDLE;
      r_parity <= 1'b0;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
    end else begin
      r_state  <= w_next;
      r_parity <= ~r_parity;
      if (w_kick) r_page <= w_data;
      if (r_state == DMA_WR) r_idx <= r_idx + 8'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DMA_IDLE:  if (w_kick) w_next = DMA_HALT;
      DMA_HALT:  w_next = r_parity ? DMA_ALIGN : DMA_RD;
      DMA_ALIGN: w_next = DMA_RD;
      DMA_RD:    w_next = DMA_WR;
      DMA_WR:    w_next = (r_idx == 8'hFF) ? DMA_IDLE : DMA_RD;
      default:   w_next = DMA_IDLE;
    endcase
  end

  // The DMA drives the same access record as the core so its reads and the
  // OAM data writes go through the ordinary region decode.
  always_comb begin
    w_acc = '{addr: address, rd: mem_r_en, wr: !mem_r_en, wdata: w_data};
    case (r_state)
      DMA_IDLE: if (w_kick) w_acc.wr = 1'b0;
      DMA_RD:   w_acc = '{addr: {r_page, r_idx}, rd: 1'b1, wr: 1'b0, wdata: 8'h00};
      DMA_WR:   w_acc = '{addr: PPU_BASE | {13'd0, OAM_DATA_IDX}, rd: 1'b0, wr: 1'b1,
                          wdata: w_sel};
      default:  w_acc = '{addr: address, rd: 1'b0, wr: 1'b0, wdata: 8'h00};
    endcase
  end
`else
  assign w_core_en = 1'b1;
  assign cpu_stall = 1'b0;

  always_comb begin
    w_acc = '{addr: address, rd: mem_r_en, wr: !mem_r_en, wdata: w_data};
  end
`endif

  assign w_region = decode_region(w_acc.addr);
  // Strobes are gated by reset so an in-flight access dies with it.
  assign w_live   = !reset;

  assign ppu_rd    = w_live && w_acc.rd && (w_region == RGN_PPU);
  assign ppu_wr    = w_live && w_acc.wr && (w_region == RGN_PPU);
  assign io_rd     = w_live && w_acc.rd && (w_region == RGN_IO);
  assign io_wr     = w_live && w_acc.wr && (w_region == RGN_IO);
  assign cart_rd   = w_live && w_acc.rd && (w_region == RGN_CART);
  assign cart_wr   = w_live && w_acc.wr && (w_region == RGN_CART);
  assign ppu_addr  = w_acc.addr[2:0];
  assign io_addr   = w_acc.addr[4:0];
  assign cart_addr = w_acc.addr;
  assign bus_wdata = w_acc.wdata;

  cpu_ram #(.AW(RAM_AW)) u_ram (
    .i_clk   (clock),
    .i_we    (w_live && w_acc.wr && (w_region == RGN_RAM)),
    .i_addr  (w_acc.addr[RAM_AW-1:0]),
    .i_wdata (w_acc.wdata),
    .o_rdata (w_ram_q)
  );

  always_comb begin
    case (r_rd_region)
      RGN_RAM:  w_sel = w_ram_q;
      RGN_PPU:  w_sel = ppu_rdata;
      RGN_IO:   w_sel = io_rdata;
      RGN_CART: w_sel = cart_rdata;
      default:  w_sel = r_open;
    endcase
  end

  // Only core reads update what the core sees; DMA reads leave r_data alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_pend   <= 1'b0;
      r_rd_region <= RGN_OPEN;
      r_open      <= 8'h00;
    end else begin
      r_rd_pend   <= w_core_en && w_acc.rd;
      r_rd_region <= w_region;
      if (r_rd_pend) r_open <= w_sel;
    end
  end

  assign r_data = r_rd_pend ? w_sel : r_open;

endmodule
